// File: rtl/hack_mem_arbiter_pkg.sv
// Shared constants, types and helpers for the Hack data-memory arbiter.
package hack_mem_pkg;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 16;
   localparam int PTR_W  = 14;
   localparam int WAIT_W = 4;

   localparam logic [ADDR_W-1:0] SCREEN_BASE_DEF  = 15'h4000;
   localparam int                SCREEN_WORDS_DEF = 8192;
   localparam logic [ADDR_W-1:0] KBD_ADDR         = 15'h6000;

   typedef enum logic [0:0] {
      CLR_IDLE = 1'b0,
      CLR_RUN  = 1'b1
   } clr_state_e;

   // Screen word offset to physical word address; wraps within the 15-bit space.
   function automatic logic [ADDR_W-1:0] screen_addr(input logic [ADDR_W-1:0] base,
                                                     input logic [PTR_W-1:0]  off);
      return base + {1'b0, off};
   endfunction

endpackage

// File: rtl/hack_mem_arbiter_if.sv
// Requester and memory-port bundle of the Hack data-memory arbiter.
// slave: the arbiter side; master: the requesters and the memory.
interface hack_mem_arbiter_if;
   import hack_mem_pkg::*;

   logic              c_req;
   logic              c_we;
   logic [ADDR_W-1:0] c_addr;
   logic [DATA_W-1:0] c_wdata;
   logic              c_gnt;
   logic              c_rvalid;
   logic [DATA_W-1:0] c_rdata;

   logic              v_req;
   logic [12:0]       v_addr;
   logic              v_gnt;
   logic              v_rvalid;
   logic [DATA_W-1:0] v_rdata;

   logic              clr_start;
   logic [DATA_W-1:0] clr_value;
   logic              clr_busy;
   logic              clr_done;

   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_in;
   logic              mem_ld;
   logic [DATA_W-1:0] mem_out;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata,
      output c_gnt, c_rvalid, c_rdata,
      input  v_req, v_addr,
      output v_gnt, v_rvalid, v_rdata,
      input  clr_start, clr_value,
      output clr_busy, clr_done,
      output mem_addr, mem_in, mem_ld,
      input  mem_out
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata,
      input  c_gnt, c_rvalid, c_rdata,
      output v_req, v_addr,
      input  v_gnt, v_rvalid, v_rdata,
      output clr_start, clr_value,
      input  clr_busy, clr_done,
      input  mem_addr, mem_in, mem_ld,
      output mem_out
   );

endinterface

// File: rtl/hack_mem_arbiter_clr_seq.sv
// Screen-clear sequencer: writes a latched fill word into every screen word,
// one word per granted cycle, then pulses clr_done once.
module hack_clr_seq
   import hack_mem_pkg::*;
#(
   parameter logic [ADDR_W-1:0] SCREEN_BASE  = SCREEN_BASE_DEF,
   parameter int                SCREEN_WORDS = SCREEN_WORDS_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr_start,
   input  logic [DATA_W-1:0] clr_value,
   input  logic              clr_gnt,
   output logic              clr_req,
   output logic [ADDR_W-1:0] clr_addr,
   output logic [DATA_W-1:0] clr_data,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SCREEN_WORDS - 1);

   clr_state_e        state_r;
   logic [PTR_W-1:0]  ptr_r;
   logic [DATA_W-1:0] value_r;
   logic              done_r;

   // Fill FSM: a start is only accepted in IDLE, so a start during RUN is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= CLR_IDLE;
         ptr_r   <= 14'd0;
         value_r <= 16'd0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            CLR_IDLE: begin
               done_r <= 1'b0;
               if (clr_start) begin
                  value_r <= clr_value;
                  ptr_r   <= 14'd0;
                  state_r <= CLR_RUN;
               end else begin
                  state_r <= CLR_IDLE;
               end
            end
            CLR_RUN: begin
               done_r <= 1'b0;
               if (clr_gnt) begin
                  if (ptr_r == LAST_PTR) begin
                     ptr_r   <= 14'd0;
                     done_r  <= 1'b1;
                     state_r <= CLR_IDLE;
                  end else begin
                     ptr_r <= ptr_r + 14'd1;
                  end
               end else begin
                  ptr_r <= ptr_r;
               end
            end
            default: begin
               state_r <= CLR_IDLE;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign clr_req  = (state_r == CLR_RUN);
   assign clr_busy = (state_r == CLR_RUN);
   assign clr_done = done_r;
   assign clr_addr = screen_addr(SCREEN_BASE, ptr_r);
   assign clr_data = value_r;

endmodule

// File: rtl/hack_mem_arbiter.sv
// Single-port Hack data-memory arbiter: CPU, video scan-out and screen clear
// share one combinational-read / clocked-write port. Fixed priority with a
// starvation guard that lets video overtake the CPU after MAX_WAIT denials.
module hack_mem_arbiter
   import hack_mem_pkg::*;
#(
   parameter int                MAX_WAIT     = 4,
   parameter logic [ADDR_W-1:0] SCREEN_BASE  = SCREEN_BASE_DEF,
   parameter int                SCREEN_WORDS = SCREEN_WORDS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   hack_mem_arbiter_if.slave   bus
);

   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

   logic [WAIT_W-1:0] wait_cnt_r;
   logic              c_gnt_s;
   logic              v_gnt_s;
   logic              clr_gnt_s;
   logic              clr_req_s;
   logic [ADDR_W-1:0] clr_addr_s;
   logic [DATA_W-1:0] clr_data_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic [DATA_W-1:0] mem_in_s;
   logic              mem_ld_s;
   logic              c_rvalid_r;
   logic [DATA_W-1:0] c_rdata_r;
   logic              v_rvalid_r;
   logic [DATA_W-1:0] v_rdata_r;

   hack_clr_seq #(
      .SCREEN_BASE  (SCREEN_BASE),
      .SCREEN_WORDS (SCREEN_WORDS)
   ) u_clr_seq (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr_start (bus.clr_start),
      .clr_value (bus.clr_value),
      .clr_gnt   (clr_gnt_s),
      .clr_req   (clr_req_s),
      .clr_addr  (clr_addr_s),
      .clr_data  (clr_data_s),
      .clr_busy  (bus.clr_busy),
      .clr_done  (bus.clr_done)
   );

   // Priority grant: starved video, then CPU, then video, then clear; none in reset.
   always_comb begin
      c_gnt_s   = 1'b0;
      v_gnt_s   = 1'b0;
      clr_gnt_s = 1'b0;
      if (!rst_n) begin
         c_gnt_s   = 1'b0;
         v_gnt_s   = 1'b0;
         clr_gnt_s = 1'b0;
      end else if (bus.v_req && (wait_cnt_r == WAIT_MAX)) begin
         v_gnt_s = 1'b1;
      end else if (bus.c_req) begin
         c_gnt_s = 1'b1;
      end else if (bus.v_req) begin
         v_gnt_s = 1'b1;
      end else if (clr_req_s) begin
         clr_gnt_s = 1'b1;
      end else begin
         c_gnt_s   = 1'b0;
         v_gnt_s   = 1'b0;
         clr_gnt_s = 1'b0;
      end
   end

   // Memory port mux follows the grant; an idle port is parked at address 0.
   always_comb begin
      mem_addr_s = 15'd0;
      mem_in_s   = 16'd0;
      mem_ld_s   = 1'b0;
      if (c_gnt_s) begin
         mem_addr_s = bus.c_addr;
         mem_in_s   = bus.c_wdata;
         mem_ld_s   = bus.c_we;
      end else if (v_gnt_s) begin
         mem_addr_s = screen_addr(SCREEN_BASE, {1'b0, bus.v_addr});
         mem_in_s   = 16'd0;
         mem_ld_s   = 1'b0;
      end else if (clr_gnt_s) begin
         mem_addr_s = clr_addr_s;
         mem_in_s   = clr_data_s;
         mem_ld_s   = 1'b1;
      end else begin
         mem_addr_s = 15'd0;
         mem_in_s   = 16'd0;
         mem_ld_s   = 1'b0;
      end
   end

   // Video starvation counter: counts denied request cycles, saturating at MAX_WAIT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_r <= 4'd0;
      end else if (bus.v_req && !v_gnt_s) begin
         if (wait_cnt_r < WAIT_MAX) begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
         end else begin
            wait_cnt_r <= WAIT_MAX;
         end
      end else begin
         wait_cnt_r <= 4'd0;
      end
   end

   // CPU read return: capture on the grant edge, valid for the following cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_rvalid_r <= 1'b0;
         c_rdata_r  <= 16'd0;
      end else begin
         c_rvalid_r <= c_gnt_s && !bus.c_we;
         if (c_gnt_s && !bus.c_we) begin
            c_rdata_r <= bus.mem_out;
         end else begin
            c_rdata_r <= c_rdata_r;
         end
      end
   end

   // Video read return: every video grant is a read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_rvalid_r <= 1'b0;
         v_rdata_r  <= 16'd0;
      end else begin
         v_rvalid_r <= v_gnt_s;
         if (v_gnt_s) begin
            v_rdata_r <= bus.mem_out;
         end else begin
            v_rdata_r <= v_rdata_r;
         end
      end
   end

   assign bus.c_gnt    = c_gnt_s;
   assign bus.v_gnt    = v_gnt_s;
   assign bus.mem_addr = mem_addr_s;
   assign bus.mem_in   = mem_in_s;
   assign bus.mem_ld   = mem_ld_s;
   assign bus.c_rvalid = c_rvalid_r;
   assign bus.c_rdata  = c_rdata_r;
   assign bus.v_rvalid = v_rvalid_r;
   assign bus.v_rdata  = v_rdata_r;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Self-checking bench for hack_mem_arbiter: directed scenarios followed by a
// randomized CPU/video phase checked against a rule-level reference model.
module tb_hack_mem_arbiter;
   import hack_mem_pkg::*;

   localparam int MAXW = 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   hack_mem_arbiter_if bus();

   hack_mem_arbiter #(
      .MAX_WAIT     (MAXW),
      .SCREEN_BASE  (15'h4000),
      .SCREEN_WORDS (8192)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Memory model: combinational read, write at the clock edge.
   logic [15:0] mem [0:32767];
   always @(posedge clk) if (bus.mem_ld) mem[bus.mem_addr] <= bus.mem_in;
   assign bus.mem_out = mem[bus.mem_addr];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // One uncontended CPU access; a read is checked against exp_rd.
   task automatic cpu_op(input logic we, input logic [14:0] addr, input logic [15:0] wd,
                         input logic [15:0] exp_rd, input string tag);
      tick();
      bus.c_req = 1'b1; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wd;
      sample();
      check({tag, "_gnt"}, 32'(bus.c_gnt), 32'(1));
      check({tag, "_ld"}, 32'(bus.mem_ld), 32'(we));
      tick();
      bus.c_req = 1'b0;
      sample();
      check({tag, "_rvalid"}, 32'(bus.c_rvalid), 32'(!we));
      if (!we) check({tag, "_rdata"}, 32'(bus.c_rdata), 32'(exp_rd));
   endtask

   // Full screen fill; optional CPU reads every 700 busy cycles and an ignored restart.
   task automatic fill_run(input logic [15:0] val, input bit traffic, input bit poke,
                           input string tag);
      int busy = 0, reads = 0, rvs = 0, dones = 0, bad = 0;
      tick();
      bus.clr_start = 1'b1; bus.clr_value = val;
      tick();
      bus.clr_start = 1'b0;
      for (int cyc = 0; cyc < 20000; cyc++) begin
         bus.c_req     = traffic && (reads < 10) && (busy % 700 == 699);
         bus.c_we      = 1'b0;
         bus.c_addr    = 15'h0010;
         bus.clr_start = poke && (busy == 50);
         bus.clr_value = (poke && busy == 50) ? 16'h1111 : val;
         sample();
         if (bus.clr_busy) busy++;
         if (bus.c_req) begin
            check({tag, "_cpu_gnt"}, 32'(bus.c_gnt), 32'(1));
            check({tag, "_cpu_ld"}, 32'(bus.mem_ld), 32'(0));
            reads++;
         end
         if (bus.c_rvalid) begin
            rvs++;
            check({tag, "_cpu_rdata"}, 32'(bus.c_rdata), 32'(16'hBEEF));
         end
         if (bus.clr_done) dones++;
         tick();
         if (dones > 0) break;
      end
      bus.c_req = 1'b0; bus.clr_start = 1'b0;
      for (int k = 0; k < 5; k++) begin
         sample();
         if (bus.clr_done) dones++;
         tick();
      end
      check({tag, "_busy_cycles"}, 32'(busy), 32'(traffic ? 8202 : 8192));
      check({tag, "_done_count"}, 32'(dones), 32'(1));
      check({tag, "_rvalid_count"}, 32'(rvs), 32'(traffic ? 10 : 0));
      for (int i = 0; i < 8192; i++) if (mem[15'h4000 + 15'(i)] !== val) bad++;
      check({tag, "_bad_words"}, 32'(bad), 32'(0));
   endtask

   logic [15:0] sh [0:63];

   initial begin
      int wcnt;
      bit ec, ev, c_hold, v_hold, prv_c, prv_v;
      logic [15:0] exp_c, exp_v, d;
      int bad;

      // Reset state, with requests asserted to check grant gating.
      rst_n = 1'b0;
      bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 15'h0001; bus.c_wdata = 16'h0;
      bus.v_req = 1'b1; bus.v_addr = 13'd0;
      bus.clr_start = 1'b0; bus.clr_value = 16'h0;
      sample();
      check("rst_c_gnt", 32'(bus.c_gnt), 32'(0));
      check("rst_v_gnt", 32'(bus.v_gnt), 32'(0));
      check("rst_mem_ld", 32'(bus.mem_ld), 32'(0));
      check("rst_c_rvalid", 32'(bus.c_rvalid), 32'(0));
      check("rst_v_rvalid", 32'(bus.v_rvalid), 32'(0));
      check("rst_c_rdata", 32'(bus.c_rdata), 32'(0));
      check("rst_v_rdata", 32'(bus.v_rdata), 32'(0));
      check("rst_clr_busy", 32'(bus.clr_busy), 32'(0));
      check("rst_clr_done", 32'(bus.clr_done), 32'(0));
      bus.c_req = 1'b0; bus.v_req = 1'b0;
      sample();
      rst_n = 1'b1;

      // CPU write then read-back.
      cpu_op(1'b1, 15'h0010, 16'hBEEF, 16'h0, "cpu_wr");
      cpu_op(1'b0, 15'h0010, 16'h0, 16'hBEEF, "cpu_rd");

      // Contention: CPU wins MAX_WAIT cycles, then starved video takes the port.
      cpu_op(1'b1, 15'h4005, 16'h5A5A, 16'h0, "pre_4005");
      tick();
      bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 15'h0010;
      bus.v_req = 1'b1; bus.v_addr = 13'd5;
      for (int k = 0; k < 5; k++) begin
         sample();
         check("cont_c_gnt", 32'(bus.c_gnt), 32'(k < 4));
         check("cont_v_gnt", 32'(bus.v_gnt), 32'(k == 4));
         check("cont_c_rvalid", 32'(bus.c_rvalid), 32'(k > 0));
         if (k > 0) check("cont_c_rdata", 32'(bus.c_rdata), 32'(16'hBEEF));
         tick();
      end
      bus.c_req = 1'b0; bus.v_req = 1'b0;
      sample();
      check("cont_v_rvalid", 32'(bus.v_rvalid), 32'(1));
      check("cont_v_rdata", 32'(bus.v_rdata), 32'(16'h5A5A));
      check("cont_c_rvalid_after", 32'(bus.c_rvalid), 32'(0));

      // Uncontended fill with an ignored restart, then spot reads at both ends.
      fill_run(16'hFFFF, 1'b0, 1'b1, "fill_idle");
      cpu_op(1'b0, 15'h4000, 16'h0, 16'hFFFF, "rd_4000");
      cpu_op(1'b0, 15'h5FFF, 16'h0, 16'hFFFF, "rd_5fff");

      // Fill with ten interleaved CPU reads.
      fill_run(16'h0A0A, 1'b1, 1'b0, "fill_traffic");

      // Reset after 100 fill writes.
      tick();
      bus.clr_start = 1'b1; bus.clr_value = 16'h00C3;
      tick();
      bus.clr_start = 1'b0;
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", 32'(bus.clr_busy), 32'(0));
      check("midrst_done", 32'(bus.clr_done), 32'(0));
      check("midrst_ld", 32'(bus.mem_ld), 32'(0));
      sample();
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         sample();
         check("midrst_post_done", 32'(bus.clr_done), 32'(0));
         check("midrst_post_busy", 32'(bus.clr_busy), 32'(0));
      end
      bad = 0;
      for (int i = 0; i < 100; i++) if (mem[15'h4000 + 15'(i)] !== 16'h00C3) bad++;
      check("midrst_filled", 32'(bad), 32'(0));
      check("midrst_4064", 32'(mem[15'h4064]), 32'(16'h0A0A));

      // Randomized phase: seed words 0..63, then random CPU/video traffic.
      for (int i = 0; i < 64; i++) begin
         d = 16'($urandom);
         sh[i] = d;
         cpu_op(1'b1, 15'(i), d, 16'h0, "seed");
      end
      wcnt = 0; c_hold = 0; v_hold = 0; prv_c = 0; prv_v = 0;
      exp_c = 16'h0; exp_v = 16'h0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         tick();
         if (!c_hold) begin
            bus.c_req   = 1'($urandom_range(0, 1));
            bus.c_we    = 1'($urandom_range(0, 1));
            bus.c_addr  = 15'($urandom_range(0, 63));
            bus.c_wdata = 16'($urandom);
         end
         if (!v_hold) begin
            bus.v_req  = ($urandom_range(0, 9) < 6);
            bus.v_addr = 13'($urandom_range(0, 15));
         end
         ev = bus.v_req && (wcnt == MAXW || !bus.c_req);
         ec = bus.c_req && !ev;
         sample();
         check("rnd_c_gnt", 32'(bus.c_gnt), 32'(ec));
         check("rnd_v_gnt", 32'(bus.v_gnt), 32'(ev));
         check("rnd_mem_ld", 32'(bus.mem_ld), 32'(ec && bus.c_we));
         check("rnd_c_rvalid", 32'(bus.c_rvalid), 32'(prv_c));
         check("rnd_v_rvalid", 32'(bus.v_rvalid), 32'(prv_v));
         if (prv_c) check("rnd_c_rdata", 32'(bus.c_rdata), 32'(exp_c));
         if (prv_v) check("rnd_v_rdata", 32'(bus.v_rdata), 32'(exp_v));
         prv_c = ec && !bus.c_we;
         if (prv_c) exp_c = sh[bus.c_addr[5:0]];
         if (ec && bus.c_we) sh[bus.c_addr[5:0]] = bus.c_wdata;
         prv_v = ev;
         if (ev) exp_v = 16'h00C3;
         wcnt = (bus.v_req && !ev) ? ((wcnt < MAXW) ? wcnt + 1 : MAXW) : 0;
         c_hold = bus.c_req && !ec;
         v_hold = bus.v_req && !ev;
      end
      tick();
      bus.c_req = 1'b0; bus.v_req = 1'b0;
      sample();
      check("rnd_last_c_rvalid", 32'(bus.c_rvalid), 32'(prv_c));
      if (prv_c) check("rnd_last_c_rdata", 32'(bus.c_rdata), 32'(exp_c));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/hack_mem_arbiter.md
# hack_mem_arbiter

Single-port access controller for the Hack data memory (RAM16K + SCREEN + KYBD map). It shares one combinational-read / clocked-write memory port between three requesters: the CPU data port, the video scan-out reader, and an internal screen-clear sequencer. Arbitration uses fixed priority with a starvation guard for video. Read data is returned registered, one cycle after grant.

## Interface
- `MAX_WAIT`, default 4: consecutive denied video cycles before video overrides the CPU (1..15).
- `SCREEN_BASE`, default 15'h4000: word address of screen word 0.
- `SCREEN_WORDS`, default 8192: number of words the clear sequencer writes.
- `clk`  in  1  single clock; all flops rise-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  CPU access request; hold `c_we`/`c_addr`/`c_wdata` stable until granted.
- `c_we`  in  1  1 = write, 0 = read.
- `c_addr`  in  15  CPU word address.
- `c_wdata`  in  16  CPU write data.
- `c_gnt`  out  1  combinational; CPU owns the memory port this cycle.
- `c_rvalid`  out  1  registered; `c_rdata` valid (granted read, previous cycle).
- `c_rdata`  out  16  registered read data.
- `v_req`  in  1  video read request.
- `v_addr`  in  13  screen word offset; physical address = `SCREEN_BASE + v_addr`.
- `v_gnt`  out  1  combinational video grant.
- `v_rvalid`  out  1  registered video read-data valid.
- `v_rdata`  out  16  registered video read data.
- `clr_start`  in  1  one-cycle pulse; start a screen fill.
- `clr_value`  in  16  fill word, sampled on accepted `clr_start`.
- `clr_busy`  out  1  fill in progress.
- `clr_done`  out  1  one-cycle pulse after the last fill write.
- `mem_addr`  out  15  memory address.
- `mem_in`  out  16  memory write data.
- `mem_ld`  out  1  memory write enable; write commits at the next `clk` edge.
- `mem_out`  in  16  memory combinational read data.

## Operation
- At most one grant per cycle. Priority is evaluated each cycle:
  1. Video, if `v_req` and `wait_cnt == MAX_WAIT`.
  2. CPU, if `c_req`.
  3. Video, if `v_req`.
  4. Clear sequencer, if `clr_busy`.
- Memory mux follows the grant:
  - CPU: `c_addr`, `c_wdata`, `mem_ld = c_we`.
  - Video: `SCREEN_BASE + v_addr` (15-bit wrap), `mem_ld = 0`.
  - Clear: `SCREEN_BASE + ptr`, `clr_value`, `mem_ld = 1`.
  - No grant: `mem_ld = 0`, `mem_addr = 0`.
- Read return: on a granted read, `mem_out` is captured into `*_rdata` at that edge, and `*_rvalid` is high for exactly the next cycle. Writes produce no `rvalid`.
- `rdata` holds its value until the next granted read for that port.
- `wait_cnt` (4 bits):
  - Increments, saturating at `MAX_WAIT`, each cycle `v_req` is high and `v_gnt` is low.
  - Clears on `v_gnt` or when `v_req` is low.
- Clear FSM, states IDLE and RUN:
  - IDLE: `clr_start` latches `clr_value`, sets `ptr = 0`, goes to RUN.
  - RUN: each granted cycle writes one word and increments `ptr` (14 bits).
  - A grant with `ptr == SCREEN_WORDS-1` returns to IDLE, and `clr_done` pulses in the following cycle.
  - `clr_start` while in RUN is ignored.
  - `clr_start` is accepted in the same cycle `clr_done` pulses.
- CPU writes into the screen region during a fill are legal. Words not yet reached are overwritten by the fill. This is the software's responsibility.
- The fill may stall indefinitely under continuous CPU/video traffic; it has no starvation guard.

## Timing
- Grant latency: 0 cycles (same cycle as `req`) when no higher-priority requester is active.
- Read data latency: 1 cycle after grant.
- Write commit: at the grant edge.
- Full fill, uncontended: `SCREEN_WORDS` cycles of RUN, plus 1 cycle for `clr_done`.
- Reset values: `c_gnt`, `v_gnt`, `mem_ld`, `c_rvalid`, `v_rvalid`, `clr_busy`, `clr_done` = 0; `c_rdata`, `v_rdata` = 0; `wait_cnt` = 0; FSM = IDLE; `ptr` = 0.
- Grants and `mem_ld` are gated low while `rst_n` = 0.
- Reset mid-fill aborts to IDLE with no `clr_done`; words already written remain.
- Reset between a grant and its `rvalid` suppresses that `rvalid`.

## Structure
- Package `hack_mem_pkg` holds:
  - `ADDR_W = 15`, `DATA_W = 16`.
  - `SCREEN_BASE_DEF = 15'h4000`, `SCREEN_WORDS_DEF = 8192`.
  - `KBD_ADDR`.
  - Clear FSM state enum `{CLR_IDLE, CLR_RUN}`.
- One sub-module, `hack_clr_seq`, contains:
  - The fill FSM, `ptr`, and the latched `clr_value`.
  - Outputs `clr_req`, `clr_addr`, `clr_data`; input `clr_gnt`.
- The top level holds the arbiter, `wait_cnt`, memory mux and read-return registers.

## Test plan
- **CPU write/read:** CPU writes 16'hBEEF to 15'h0010, then reads it → `c_gnt` same cycle each time; `c_rvalid` and `c_rdata = 16'hBEEF` one cycle after the read grant.
- **Contention:** `c_req` (read) and `v_req` (`v_addr = 5`) asserted together, both held, `MAX_WAIT = 4` → CPU granted 4 cycles; video granted in the 5th; `v_rdata` = word at 15'h4005.
- **Uncontended fill:** `clr_start` with `clr_value = 16'hFFFF`, no other traffic → `clr_busy` for 8192 cycles; `clr_done` pulses once; addresses 15'h4000 and 15'h5FFF read 16'hFFFF.
- **Fill under traffic:** fill with 10 interleaved CPU reads → fill pauses during each CPU grant; total duration 8192 + 10 cycles; no fill word skipped.
- **Reset mid-fill:** `rst_n` low after 100 fill writes → `clr_busy`/`clr_done` = 0 immediately; words 15'h4000–15'h4063 filled; 15'h4064 unchanged.
- **Ignored start:** `clr_start` pulsed during RUN → ignored; exactly one `clr_done`.
